ftdi_pkt_loader: RTL and testbench

// - Upstream feeder of the FTDI write path. Takes a byte stream (valid/ready) from the laser RX

---
 rtl/ftdi_pkt_loader.sv | 211 +++++++++++++++++++++
 tb/tb_ftdi_pkt_loader.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_pkt_loader.sv
// ftdi_pkt_loader: feeds a valid/ready byte stream into the FTDI 1k packet FIFO.
// Each packet is launched with a one-cycle load_1k strobe. A launch happens when the
// packet is full, when the input has been idle too long, or on an explicit flush.
// After the launch the block waits for the FIFO to drain, then holds off for a guard
// interval while the FTDI stage pads the packet out to 1024 bytes.
// Optional build macro PKT_SEQ_EN: prefixes every packet with an 8-bit sequence header.
module ftdi_pkt_loader #(
  parameter int PKT_BYTES    = 1024,
  parameter int IDLE_TIMEOUT = 4096,
  parameter int GUARD_CYCLES = 1040
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic        wrq_full,
  input  logic        wrq_empty,
  output logic        wrreq,
  output logic [7:0]  data_wr,
  output logic        load_1k,
  output logic [15:0] pkt_count,
  output logic        busy
);

  localparam int BYTE_W  = $clog2(PKT_BYTES + 1);
  localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

  localparam logic [BYTE_W-1:0]  BYTE_ONE   = BYTE_W'(1);
  localparam logic [BYTE_W-1:0]  BYTE_MAX   = BYTE_W'(PKT_BYTES);
  localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [GUARD_W-1:0] GUARD_MAX  = GUARD_W'(GUARD_CYCLES);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GUARD = 3'd4
`ifdef PKT_SEQ_EN
    ,
    ST_HDR   = 3'd5
`endif
  } state_t;

  state_t               state_reg, state_next;
  logic [BYTE_W-1:0]    byte_ct_reg, byte_ct_next;
  logic [IDLE_W-1:0]    idle_ct_reg, idle_ct_next;
  logic [GUARD_W-1:0]   guard_ct_reg, guard_ct_next;
  logic                 drain_armed_reg, drain_armed_next;
  logic [15:0]          pkt_count_reg, pkt_count_next;
`ifdef PKT_SEQ_EN
  logic [7:0]           seq_reg, seq_next;
`endif

  // Saturating increments: counters park at their terminal value instead of wrapping.
  logic [BYTE_W-1:0]    byte_ct_inc;
  logic [IDLE_W-1:0]    idle_ct_inc;
  logic [GUARD_W-1:0]   guard_ct_inc;

  assign byte_ct_inc  = (byte_ct_reg  == BYTE_MAX)  ? BYTE_MAX  : byte_ct_reg  + BYTE_W'(1);
  assign idle_ct_inc  = (idle_ct_reg  == IDLE_MAX)  ? IDLE_MAX  : idle_ct_reg  + IDLE_W'(1);
  assign guard_ct_inc = (guard_ct_reg == GUARD_MAX) ? GUARD_MAX : guard_ct_reg + GUARD_W'(1);

  // Raw combinational outputs before the reset gate.
  logic       ready_int;
  logic       wr_int;
  logic [7:0] data_int;
  logic       load_int;

  // State and counter registers with synchronous reset; a reset abandons any open packet.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      byte_ct_reg     <= '0;
      idle_ct_reg     <= '0;
      guard_ct_reg    <= '0;
      drain_armed_reg <= 1'b0;
      pkt_count_reg   <= '0;
`ifdef PKT_SEQ_EN
      seq_reg         <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      byte_ct_reg     <= byte_ct_next;
      idle_ct_reg     <= idle_ct_next;
      guard_ct_reg    <= guard_ct_next;
      drain_armed_reg <= drain_armed_next;
      pkt_count_reg   <= pkt_count_next;
`ifdef PKT_SEQ_EN
      seq_reg         <= seq_next;
`endif
    end
  end

  // Next-state, counter updates and FIFO/handshake outputs.
  always_comb begin
    state_next       = state_reg;
    byte_ct_next     = byte_ct_reg;
    idle_ct_next     = idle_ct_reg;
    guard_ct_next    = guard_ct_reg;
    drain_armed_next = drain_armed_reg;
    pkt_count_next   = pkt_count_reg;
`ifdef PKT_SEQ_EN
    seq_next         = seq_reg;
`endif
    ready_int        = 1'b0;
    wr_int           = 1'b0;
    data_int         = 8'h00;
    load_int         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        byte_ct_next = '0;
        idle_ct_next = '0;
`ifdef PKT_SEQ_EN
        // Hold the first byte back; the header has to go into the FIFO ahead of it.
        if (in_valid && !wrq_full) begin
          state_next = ST_HDR;
        end
`else
        // The first byte is payload and is written straight away.
        ready_int = !wrq_full;
        if (in_valid && !wrq_full) begin
          wr_int       = 1'b1;
          data_int     = in_data;
          byte_ct_next = BYTE_ONE;
          state_next   = (BYTE_ONE == BYTE_MAX) ? ST_LOAD : ST_FILL;
        end
`endif
      end

`ifdef PKT_SEQ_EN
      ST_HDR: begin
        // Header byte occupies the first slot of the packet.
        wr_int       = 1'b1;
        data_int     = seq_reg;
        byte_ct_next = BYTE_ONE;
        idle_ct_next = '0;
        state_next   = (BYTE_ONE == BYTE_MAX) ? ST_LOAD : ST_FILL;
      end
`endif

      ST_FILL: begin
        ready_int = !wrq_full && (byte_ct_reg < BYTE_MAX);
        if (in_valid && ready_int) begin
          wr_int       = 1'b1;
          data_int     = in_data;
          byte_ct_next = byte_ct_inc;
          idle_ct_next = '0;
        end else begin
          // Stalls on wrq_full also count as idle so a stuck packet still launches.
          idle_ct_next = idle_ct_inc;
        end
        // Launch decisions look at the post-update counts, so a byte taken this cycle
        // (including one that arrives alongside flush) is part of the launched packet.
        if ((byte_ct_next == BYTE_MAX) ||
            (flush && (byte_ct_next != '0)) ||
            (idle_ct_next == IDLE_LAST)) begin
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        load_int         = 1'b1;
        pkt_count_next   = pkt_count_reg + 16'd1;
        drain_armed_next = 1'b0;
`ifdef PKT_SEQ_EN
        seq_next         = seq_reg + 8'd1;
`endif
        state_next       = ST_DRAIN;
      end

      ST_DRAIN: begin
        // The first DRAIN cycle ignores wrq_empty: the FIFO flag may still reflect the
        // state before the launch was seen downstream.
        drain_armed_next = 1'b1;
        if (drain_armed_reg && wrq_empty) begin
          guard_ct_next = '0;
          state_next    = ST_GUARD;
        end
      end

      ST_GUARD: begin
        guard_ct_next = guard_ct_inc;
        if (guard_ct_reg == GUARD_LAST) begin
          byte_ct_next = '0;
          idle_ct_next = '0;
          state_next   = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet in the cycle reset is asserted.
  assign in_ready  = ready_int && !reset;
  assign wrreq     = wr_int && !reset;
  assign data_wr   = reset ? 8'h00 : data_int;
  assign load_1k   = load_int && !reset;
  assign pkt_count = pkt_count_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ftdi_pkt_loader.sv
// Testbench for ftdi_pkt_loader: scenario tasks plus a write-side scoreboard.
module tb_ftdi_pkt_loader;

  localparam int PKT_BYTES    = 1024;
  localparam int IDLE_TIMEOUT = 4096;
  localparam int GUARD_CYCLES = 1040;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        wrq_full = 1'b0;
  logic        wrq_empty = 1'b0;
  logic        wrreq;
  logic [7:0]  data_wr;
  logic        load_1k;
  logic [15:0] pkt_count;
  logic        busy;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int wr_count = 0;
  int load_count = 0;
  int last_wr_cyc = 0;
  int load_cyc = 0;
  int exp_pkts = 0;
  logic [7:0] sb[$];

  ftdi_pkt_loader #(
    .PKT_BYTES(PKT_BYTES),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush(flush),
    .wrq_full(wrq_full),
    .wrq_empty(wrq_empty),
    .wrreq(wrreq),
    .data_wr(data_wr),
    .load_1k(load_1k),
    .pkt_count(pkt_count),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Write monitor: every FIFO write must match the next expected byte.
  always @(negedge clock) begin
    logic [7:0] exp_b;
    #1;
    if (wrreq === 1'b1) begin
      wr_count++;
      last_wr_cyc = cyc;
      tests_run++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_write: data_wr=%02h written, required no write", data_wr);
      end else begin
        exp_b = sb.pop_front();
        if (data_wr !== exp_b) begin
          fails++;
          $display("FAIL sb_data: data_wr=%02h, required %02h", data_wr, exp_b);
        end
      end
    end
    if (load_1k === 1'b1) begin
      load_count++;
      load_cyc = cyc;
    end
  end

  // Offer one byte; push it to the scoreboard at the cycle it is accepted.
  task automatic drive_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 4 && !ok; i++) begin
      @(negedge clock);
      if (in_ready === 1'b1) begin
        sb.push_back(b);
        ok = 1'b1;
      end
      @(posedge clock); #1;
    end
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL accept: byte %02h never taken, required acceptance", b);
    end
  endtask

  // Bounded wait for the next load_1k after load_count==base.
  task automatic wait_load(input int base, input int bound);
    int n;
    n = 0;
    while (load_count == base && n < bound) begin
      @(posedge clock); #1;
      n++;
    end
    tests_run++;
    if (load_count == base) begin
      fails++;
      $display("FAIL load_wait: no load_1k in %0d cycles, required one", bound);
    end
  endtask

  // Let the FIFO report empty and wait (bounded) for the loader to return to IDLE.
  task automatic wait_idle();
    int n;
    n = 0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    wrq_full  = 1'b0;
    wrq_empty = 1'b1;
    while (busy !== 1'b0 && n < GUARD_CYCLES + 50) begin
      @(posedge clock); #1;
      n++;
    end
    wrq_empty = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    tests_run++;
    if (in_ready !== 1'b0 || wrreq !== 1'b0 || load_1k !== 1'b0 || data_wr !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: in_ready=%b wrreq=%b load_1k=%b data_wr=%02h, required 0 0 0 00",
               in_ready, wrreq, load_1k, data_wr);
    end
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_pkts = 0;
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b0 || pkt_count !== 16'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: busy=%b pkt_count=%0d in_ready=%b, required 0 0 1",
               busy, pkt_count, in_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_full_packet();
    int base_wr, base_ld, start, n;
    bit rdy_seen;
    base_wr = wr_count;
    base_ld = load_count;
    start   = cyc;
    for (int i = 0; i < PKT_BYTES; i++) drive_byte(8'(i % 256));
    tests_run++;
    if (cyc - start != PKT_BYTES) begin
      fails++;
      $display("FAIL full_b2b: %0d cycles for packet, required %0d", cyc - start, PKT_BYTES);
    end
    // Keep offering a byte; nothing more may be taken until the loader is idle again.
    rdy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clock); #1;
    end
    exp_pkts++;
    tests_run++;
    if (load_count - base_ld != 1 || load_cyc - last_wr_cyc != 1) begin
      fails++;
      $display("FAIL full_load: loads=%0d gap=%0d, required 1 load 1 cycle after last write",
               load_count - base_ld, load_cyc - last_wr_cyc);
    end
    tests_run++;
    if (wr_count - base_wr != PKT_BYTES || pkt_count !== 16'(exp_pkts)) begin
      fails++;
      $display("FAIL full_count: writes=%0d pkt_count=%0d, required %0d %0d",
               wr_count - base_wr, pkt_count, PKT_BYTES, exp_pkts);
    end
    in_valid  = 1'b0;
    wrq_empty = 1'b1;
    @(posedge clock); #1;
    n = 0;
    while (busy === 1'b1 && n < GUARD_CYCLES + 50) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      n++;
      @(posedge clock); #1;
    end
    wrq_empty = 1'b0;
    tests_run++;
    if (n != GUARD_CYCLES || rdy_seen) begin
      fails++;
      $display("FAIL full_guard: guard=%0d cycles in_ready_seen=%b, required %0d 0",
               n, rdy_seen, GUARD_CYCLES);
    end
  endtask

  task automatic test_timeout();
    int base_wr, base_ld;
    base_wr = wr_count;
    base_ld = load_count;
    for (int i = 0; i < 10; i++) drive_byte(8'(8'h30 + i));
    in_valid = 1'b0;
    wait_load(base_ld, IDLE_TIMEOUT + 100);
    exp_pkts++;
    tests_run++;
    if (load_cyc - last_wr_cyc != IDLE_TIMEOUT || wr_count - base_wr != 10) begin
      fails++;
      $display("FAIL timeout_gap: gap=%0d writes=%0d, required %0d 10",
               load_cyc - last_wr_cyc, wr_count - base_wr, IDLE_TIMEOUT);
    end
    repeat (5) begin @(posedge clock); #1; end
    tests_run++;
    if (busy !== 1'b1 || load_count - base_ld != 1 || pkt_count !== 16'(exp_pkts)) begin
      fails++;
      $display("FAIL timeout_drain: busy=%b loads=%0d pkt_count=%0d, required 1 1 %0d",
               busy, load_count - base_ld, pkt_count, exp_pkts);
    end
    wait_idle();
  endtask

  task automatic test_flush();
    int base_wr, base_ld;
    base_wr = wr_count;
    base_ld = load_count;
    for (int i = 0; i < 5; i++) drive_byte(8'(8'hC0 + i));
    flush = 1'b1;
    drive_byte(8'hC5);
    flush    = 1'b0;
    in_valid = 1'b0;
    wait_load(base_ld, 10);
    exp_pkts++;
    tests_run++;
    if (wr_count - base_wr != 6 || load_cyc - last_wr_cyc != 1) begin
      fails++;
      $display("FAIL flush_pkt: writes=%0d gap=%0d, required 6 1",
               wr_count - base_wr, load_cyc - last_wr_cyc);
    end
    wait_idle();
    // Flush while idle must not launch an empty packet.
    base_ld = load_count;
    flush = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    flush = 1'b0;
    repeat (20) begin @(posedge clock); #1; end
    tests_run++;
    if (load_count != base_ld || busy !== 1'b0 || pkt_count !== 16'(exp_pkts)) begin
      fails++;
      $display("FAIL flush_idle: loads=%0d busy=%b pkt_count=%0d, required 0 0 %0d",
               load_count - base_ld, busy, pkt_count, exp_pkts);
    end
  endtask

  task automatic test_full_stall();
    int base_wr, base_ld, stall_wr;
    bit rdy_seen;
    base_ld  = load_count;
    wrq_full = 1'b1;
    @(negedge clock);
    tests_run++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL stall_idle: in_ready=%b, required 0", in_ready);
    end
    @(posedge clock); #1;
    wrq_full = 1'b0;
    base_wr  = wr_count;
    for (int i = 0; i < 300; i++) drive_byte(8'(i * 7));
    wrq_full = 1'b1;
    in_data  = 8'hEE;
    in_valid = 1'b1;
    stall_wr = wr_count;
    rdy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clock); #1;
    end
    tests_run++;
    if (rdy_seen || wr_count != stall_wr) begin
      fails++;
      $display("FAIL stall_hold: in_ready_seen=%b writes=%0d, required 0 0",
               rdy_seen, wr_count - stall_wr);
    end
    wait_load(base_ld, IDLE_TIMEOUT + 100);
    exp_pkts++;
    in_valid = 1'b0;
    tests_run++;
    if (load_cyc - last_wr_cyc != IDLE_TIMEOUT || wr_count - base_wr != 300) begin
      fails++;
      $display("FAIL stall_timeout: gap=%0d writes=%0d, required %0d 300",
               load_cyc - last_wr_cyc, wr_count - base_wr, IDLE_TIMEOUT);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int base_wr, base_ld;
    base_ld = load_count;
    for (int i = 0; i < 500; i++) drive_byte(8'(i));
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    tests_run++;
    if (wrreq !== 1'b0 || load_1k !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_out: wrreq=%b load_1k=%b in_ready=%b, required 0 0 0",
               wrreq, load_1k, in_ready);
    end
    @(posedge clock); #1;
    reset    = 1'b0;
    exp_pkts = 0;
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b0 || pkt_count !== 16'd0) begin
      fails++;
      $display("FAIL rstmid_state: busy=%b pkt_count=%0d, required 0 0", busy, pkt_count);
    end
    repeat (30) begin @(posedge clock); #1; end
    tests_run++;
    if (load_count != base_ld) begin
      fails++;
      $display("FAIL rstmid_load: loads=%0d, required 0", load_count - base_ld);
    end
    // A fresh full packet proves the byte count restarted from zero.
    base_wr = wr_count;
    for (int i = 0; i < PKT_BYTES; i++) drive_byte(8'(255 - (i % 256)));
    in_valid = 1'b0;
    wait_load(base_ld, 10);
    exp_pkts++;
    @(posedge clock); #1;
    tests_run++;
    if (wr_count - base_wr != PKT_BYTES || load_cyc - last_wr_cyc != 1 ||
        pkt_count !== 16'(exp_pkts)) begin
      fails++;
      $display("FAIL rstmid_restart: writes=%0d gap=%0d pkt_count=%0d, required %0d 1 %0d",
               wr_count - base_wr, load_cyc - last_wr_cyc, pkt_count, PKT_BYTES, exp_pkts);
    end
    wait_idle();
  endtask

`ifdef PKT_SEQ_EN
  task automatic test_seq();
    int base_ld;
    for (int k = 0; k < 3; k++) begin
      base_ld = load_count;
      sb.push_back(8'(k));
      for (int i = 0; i < 3; i++) drive_byte(8'(8'h10 * k + i));
      flush = 1'b1;
      drive_byte(8'(8'h10 * k + 3));
      flush    = 1'b0;
      in_valid = 1'b0;
      wait_load(base_ld, 10);
      exp_pkts++;
      @(posedge clock); #1;
      tests_run++;
      if (pkt_count !== 16'(exp_pkts)) begin
        fails++;
        $display("FAIL seq_count: pkt_count=%0d, required %0d", pkt_count, exp_pkts);
      end
      wait_idle();
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
`ifdef PKT_SEQ_EN
    test_seq();
`else
    test_full_packet();
    test_timeout();
    test_flush();
    test_full_stall();
    test_reset_mid();
`endif
    repeat (3) begin @(posedge clock); #1; end
    tests_run++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d bytes never written, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
